// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_pkg
//  Purpose  : Shared widths and FSM state encoding for the PE feeder.
//  Revision : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 8;
    localparam int ROW_W   = PIX_W * ROW_PIX;
    localparam int FILT_W  = 72;
    localparam int BIAS_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pe_row_window.sv
`default_nettype none
// ============================================================================
//  Module   : pe_row_window
//  Purpose  : Three-row sliding window register (shift up, load bottom, clear).
//  Revision : 1.0  initial release
// ============================================================================
module pe_row_window
    import pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_load,
    input  logic [ROW_W-1:0] i_data,
    output logic [ROW_W-1:0] o_row1,
    output logic [ROW_W-1:0] o_row2,
    output logic [ROW_W-1:0] o_row3
);

    logic [ROW_W-1:0] r_row1;
    logic [ROW_W-1:0] r_row2;
    logic [ROW_W-1:0] r_row3;

    // Shift and load may coincide: the bottom row moves up while new data enters.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row1 <= '0;
            r_row2 <= '0;
            r_row3 <= '0;
        end else begin
            if (i_shift) begin
                r_row1 <= r_row2;
                r_row2 <= r_row3;
            end
            if (i_load) begin
                r_row3 <= i_data;
            end
        end
    end

    assign o_row1 = r_row1;
    assign o_row2 = r_row2;
    assign o_row3 = r_row3;

endmodule
`default_nettype wire

// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pe_feeder
//  Purpose  : Streams 3-row ifmap windows and registered weights to a PE array.
//             Optional macro PE_FEEDER_ZERO_PAD_EN adds zero rows above/below.
//  Revision : 1.0  initial release
// ============================================================================
module pe_feeder
    import pe_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        base_addr,
    input  logic              w_valid,
    input  logic [FILT_W-1:0] w_filter,
    input  logic [BIAS_W-1:0] w_bias,
    output logic              mem_ren,
    output logic [7:0]        mem_addr,
    input  logic [ROW_W-1:0]  mem_rdata,
    output logic [ROW_W-1:0]  ifmapIn1,
    output logic [ROW_W-1:0]  ifmapIn2,
    output logic [ROW_W-1:0]  ifmapIn3,
    output logic [FILT_W-1:0] filter,
    output logic [BIAS_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(ROWS + 3);
`ifdef PE_FEEDER_ZERO_PAD_EN
    localparam int NWIN = ROWS;
`else
    localparam int NWIN = ROWS - 2;
`endif
    localparam logic [CNT_W-1:0] c_LAST_WIN = CNT_W'(NWIN - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ld_cnt;
    logic [CNT_W-1:0]   r_row;      // next virtual row to fetch
    logic [CNT_W-1:0]   r_win;
    logic [7:0]         r_addr;
    logic               r_pend;
    logic               r_pend_zero;
    logic               r_done;
    logic [FILT_W-1:0]  r_filter;
    logic [BIAS_W-1:0]  r_bias;

    logic               w_virt;
    logic               w_issue;
    logic               w_shift;
    logic               w_load;
    logic               w_accept;
    logic               w_last;
    logic [ROW_W-1:0]   w_row_data;

`ifdef PE_FEEDER_ZERO_PAD_EN
    assign w_virt = (r_row == '0) || (r_row == CNT_W'(ROWS + 1));
`else
    assign w_virt = 1'b0;
`endif

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_row_data = r_pend_zero ? '0 : mem_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            // Cycles 0..2 fetch rows 0..2; cycles 1..3 capture the returning data.
            S_LOAD: begin
                w_issue = (r_ld_cnt != 2'd3);
                w_shift = r_pend;
                w_load  = r_pend;
                if (r_ld_cnt == 2'd3) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (out_ready) begin
                    w_shift = 1'b1;
                    if (r_win == c_LAST_WIN) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_load      = 1'b1;
                w_state_nxt = S_STREAM;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= '0;
            r_row       <= '0;
            r_win       <= '0;
            r_addr      <= '0;
            r_pend      <= 1'b0;
            r_pend_zero <= 1'b0;
            r_done      <= 1'b0;
            r_filter    <= '0;
            r_bias      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_last;
            r_pend      <= w_issue;
            r_pend_zero <= w_issue && w_virt;
            if (w_accept) begin
                r_addr   <= base_addr;
                r_row    <= '0;
                r_win    <= '0;
                r_ld_cnt <= '0;
            end else begin
                if (r_state == S_LOAD) r_ld_cnt <= r_ld_cnt + 2'd1;
                if (w_issue) begin
                    r_row <= r_row + c_ONE;
                    if (!w_virt) r_addr <= r_addr + 8'd1;
                end
                if (r_state == S_STREAM && out_ready) r_win <= r_win + c_ONE;
            end
            if (r_state == S_IDLE && w_valid) begin
                r_filter <= w_filter;
                r_bias   <= w_bias;
            end
        end
    end

    pe_row_window u_win (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_shift (w_shift),
        .i_load  (w_load),
        .i_data  (w_row_data),
        .o_row1  (ifmapIn1),
        .o_row2  (ifmapIn2),
        .o_row3  (ifmapIn3)
    );

    assign mem_ren   = w_issue && !w_virt;
    assign mem_addr  = r_addr;
    assign out_valid = (r_state == S_STREAM);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign filter    = r_filter;
    assign bias      = r_bias;

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_feeder
//  Purpose  : Scoreboard bench for pe_feeder (windows, addresses, weights, reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_feeder;

    localparam int ROWS = 8;
`ifdef PE_FEEDER_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int NWIN = ROWS - 2 + 2 * PAD;
    localparam logic [71:0] c_FILT = 72'hF9ED1A0DF1F410_0AF1;
    localparam logic [15:0] c_BIAS = 16'h01CB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        w_valid;
    logic [71:0] w_filter;
    logic [15:0] w_bias;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [63:0] mem_rdata = '0;
    logic [63:0] ifmapIn1, ifmapIn2, ifmapIn3;
    logic [71:0] filter;
    logic [15:0] bias;
    logic        out_valid, out_ready, busy, done;

    typedef struct packed {
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] r3;
    } win_t;

    logic [63:0] mem [256];
    win_t        exp_win_q [$];
    logic [7:0]  exp_addr_q [$];
    int checks = 0, failures = 0;
    int hs_total = 0, ren_total = 0, done_total = 0;

    pe_feeder #(.ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .w_valid(w_valid), .w_filter(w_filter), .w_bias(w_bias),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ifmapIn1(ifmapIn1), .ifmapIn2(ifmapIn2), .ifmapIn3(ifmapIn3),
        .filter(filter), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Virtual row v: with padding rows 0 and ROWS+1 are zero, real row j holds byte j+1.
    function automatic logic [63:0] vrow(input int v);
        logic [7:0] b;
        if (PAD == 1) begin
            if (v == 0 || v == ROWS + 1) return 64'd0;
            b = 8'(v);
        end else begin
            b = 8'(v + 1);
        end
        return {8{b}};
    endfunction

    task automatic push_frame(input logic [7:0] b);
        win_t w;
        for (int a = 0; a < 256; a++) mem[a] = {8{8'(a - int'(b) + 1)}};
        for (int k = 0; k < NWIN; k++) begin
            w.r1 = vrow(k); w.r2 = vrow(k + 1); w.r3 = vrow(k + 2);
            exp_win_q.push_back(w);
        end
        for (int j = 0; j < ROWS; j++) exp_addr_q.push_back(8'(int'(b) + j));
    endtask

    task automatic start_frame(input logic [7:0] b);
        push_frame(b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int r0, input int h0);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        chk("busy_at_done", 72'(busy), 72'd0);
        @(posedge clk); #1;
        chk("done_count", 72'(done_total - d0), 72'd1);
        chk("ren_count", 72'(ren_total - r0), 72'(ROWS));
        chk("win_count", 72'(hs_total - h0), 72'(NWIN));
        chk("win_q_left", 72'(exp_win_q.size()), 72'd0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_total < target && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (hs_total < target) begin
            checks++; failures++;
            $display("FAIL hs_timeout actual=%0d expected=%0d", hs_total, target);
        end
    endtask

    // Monitor: pops expected addresses and windows on every read / handshake.
    always @(negedge clk) begin
        win_t w;
        logic [7:0] ea;
        if (rst === 1'b0) begin
            if (mem_ren) begin
                ren_total++;
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_mem_ren actual=%h expected=none", mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", 72'(mem_addr), 72'(ea));
                end
            end
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_win_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_window actual=%h expected=none", ifmapIn1);
                end else begin
                    w = exp_win_q.pop_front();
                    chk("ifmapIn1", 72'(ifmapIn1), 72'(w.r1));
                    chk("ifmapIn2", 72'(ifmapIn2), 72'(w.r2));
                    chk("ifmapIn3", 72'(ifmapIn3), 72'(w.r3));
                end
            end
            if (done) done_total++;
        end
    end

    initial begin
        int d0, r0, h0;
        rst = 1'b1; start = 1'b0; base_addr = '0; w_valid = 1'b0;
        w_filter = '0; w_bias = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ifmapIn1", 72'(ifmapIn1), 72'd0);
        chk("rst_ifmapIn3", 72'(ifmapIn3), 72'd0);
        chk("rst_filter", filter, 72'd0);
        chk("rst_outs", {out_valid, mem_ren, busy, done, mem_addr}, 72'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: base 0x10, start together with a weight load, latency check
        d0 = done_total; r0 = ren_total; h0 = hs_total;
        w_valid = 1'b1; w_filter = c_FILT; w_bias = c_BIAS;
        start_frame(8'h10);
        chk("filter_load", filter, c_FILT);
        chk("bias_load", 72'(bias), 72'(c_BIAS));
        chk("busy_load", 72'(busy), 72'd1);
        w_filter = '1; w_bias = '1;          // still held high while in LOAD
        repeat (3) @(posedge clk);
        #1;
        chk("valid_cycle4", 72'(out_valid), 72'd0);
        @(posedge clk); #1;
        chk("valid_cycle5", 72'(out_valid), 72'd1);
        @(posedge clk); #1;
        chk("filter_hold", filter, c_FILT);
        chk("bias_hold", 72'(bias), 72'(c_BIAS));
        w_valid = 1'b0;
        wait_done(d0, r0, h0);

        // Frame 2: back-pressure on window 2
        d0 = done_total; r0 = ren_total; h0 = hs_total;
        start_frame(8'h20);
        wait_hs(h0 + 2);
        out_ready = 1'b0;
        for (int n = 0; n < 20 && out_valid !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 72'(out_valid), 72'd1);
            chk("stall_ren", 72'(mem_ren), 72'd0);
            chk("stall_in1", 72'(ifmapIn1), 72'(vrow(2)));
            chk("stall_in3", 72'(ifmapIn3), 72'(vrow(4)));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(d0, r0, h0);

        // Frame 3: address wrap
        d0 = done_total; r0 = ren_total; h0 = hs_total;
        start_frame(8'hFE);
        wait_done(d0, r0, h0);
        chk("addr_q_left", 72'(exp_addr_q.size()), 72'd0);

        // Frame 4: reset mid-frame, then clean restart
        start_frame(8'h40);
        wait_hs(hs_total + 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rows", 72'(ifmapIn1 | ifmapIn2 | ifmapIn3), 72'd0);
        chk("midrst_w", {filter | {56'd0, bias}}, 72'd0);
        chk("midrst_outs", {out_valid, mem_ren, busy, done, mem_addr}, 72'd0);
        rst = 1'b0;
        exp_win_q.delete();
        exp_addr_q.delete();
        d0 = done_total;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 72'(done_total - d0), 72'd0);
        r0 = ren_total; h0 = hs_total;
        start_frame(8'h50);
        wait_done(d0, r0, h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 8: image rows per frame; legal range 3..200.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: frame start request; sampled only in IDLE.
REQ-005 SHALL have port base_addr, input, 8 bits: first row address; latched on accepted start.
REQ-006 SHALL have port w_valid, input, 1 bit: weight load strobe; sampled only in IDLE.
REQ-007 SHALL have port w_filter, input, 72 bits: nine signed 8-bit taps.
REQ-008 SHALL have port w_bias, input, 16 bits: signed bias.
REQ-009 SHALL have port mem_ren, output, 1 bit: row read strobe to the ifmap SRAM.
REQ-010 SHALL have port mem_addr, output, 8 bits: row address.
REQ-011 SHALL have port mem_rdata, input, 64 bits: eight 8-bit pixels; valid exactly 1 cycle after mem_ren.
REQ-012 SHALL have ports ifmapIn1, ifmapIn2 and ifmapIn3, output, 64 bits each: top, middle and bottom rows of the window to the PE array.
REQ-013 SHALL have port filter, output, 72 bits, and port bias, output, 16 bits: registered weights to the PE array.
REQ-014 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: window handshake.
REQ-015 SHALL have ports busy and done, output, 1 bit each: frame active, and a 1-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement the FSM IDLE->LOAD->STREAM->WAIT->STREAM...->IDLE; an accepted start moves IDLE to LOAD.
REQ-017 In LOAD, SHALL assert mem_ren for 3 consecutive cycles (addresses base, base+1, base+2) starting the cycle after start; out_valid SHALL rise 5 cycles after the start cycle.
REQ-018 In STREAM, SHALL hold out_valid=1; ifmapIn1/2/3 = rows k, k+1, k+2 for window k.
REQ-019 While out_valid=1 and out_ready=0, all outputs SHALL stay stable.
REQ-020 On handshake (out_valid & out_ready) with windows remaining: the same cycle SHALL assert mem_ren for row k+3 and shift in1<-in2, in2<-in3 at the edge; WAIT captures mem_rdata into in3; out_valid SHALL reassert 2 cycles after the handshake.
REQ-021 On handshake of the last window (ROWS-2 windows total): no read; SHALL return to IDLE, pulse done for 1 cycle and drop busy.
REQ-022 mem_addr SHALL wrap modulo 256.
REQ-023 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-024 w_valid in IDLE SHALL latch w_filter/w_bias into filter/bias on the next edge; w_valid outside IDLE SHALL be ignored; start and w_valid together SHALL both take effect.
REQ-025 Row and window counters SHALL be sized to hold ROWS+2.

Reset
REQ-026 rst SHALL force IDLE and clear ifmapIn1/2/3, filter, bias, out_valid, mem_ren, mem_addr, busy and done to 0.
REQ-027 rst mid-frame SHALL abandon the frame with no done pulse; the next start SHALL restart cleanly.

Configuration
REQ-028 With macro PE_FEEDER_ZERO_PAD_EN defined, SHALL add a virtual all-zero row above row 0 and below row ROWS-1, giving ROWS windows.
REQ-029 With padding, window 0 SHALL be (0, row0, row1), the last window SHALL be (rowROWS-2, rowROWS-1, 0), and virtual rows SHALL be inserted with no mem_ren.
REQ-030 Without the macro, there SHALL be no padding, ROWS-2 windows, and no padding logic.

Structure
REQ-031 Package pe_pkg SHALL hold PIX_W=8, ROW_PIX=8, ROW_W=64, FILT_W=72, BIAS_W=16 and the FSM state enum.
REQ-032 Sub-module pe_row_window SHALL hold the 3-row shift register (shift, load-bottom, clear).

Verification
REQ-033 Reset, then start with base=0x10 and ROWS=8, memory row i = {8{8'(i+1)}}, out_ready=1 -> reads 0x10..0x17, 6 windows, first window (01..,02..,03..), done exactly once.
REQ-034 out_ready=0 for 5 cycles on window 2 -> outputs frozen; no mem_ren until the handshake.
REQ-035 base=0xFE -> addresses FE, FF, 00, 01...; no error.
REQ-036 w_valid with filter=72'hF9ED1A0DF1F410_0AF1 and bias=16'h01CB in IDLE -> outputs match; w_valid during STREAM -> unchanged.
REQ-037 rst at window 3 -> all outputs 0 next cycle; restart produces a correct full frame.
REQ-038 PE_FEEDER_ZERO_PAD_EN build -> 8 windows; first ifmapIn1=0; last ifmapIn3=0; exactly 8 mem_ren.
